zbt_port_arbiter: RTL and testbench

// Shares the single 36-bit ZBT SRAM port between the camera write stream (NTSC-to-ZBT packer) and the display read stream (VRAM display fetch).

---
 rtl/zbt_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_zbt_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/zbt_port_arbiter.sv
// Shares one ZBT SRAM port between a buffered camera write stream and a
// priority display read stream, with a frame-aligned image freeze.
module zbt_port_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [35:0] wr_data,
    input  logic        wr_frame,
    input  logic        freeze_req,
    input  logic        disp_req,
    input  logic [18:0] disp_addr,
    output logic [35:0] disp_data,
    output logic        disp_valid,
    output logic [18:0] ram_addr,
    output logic        ram_we,
    output logic [35:0] ram_wdata,
    input  logic [35:0] ram_rdata,
    output logic        frozen,
    output logic        wr_overflow,
    output logic [15:0] drop_count
);

    // state       | meaning
    // RUN         | camera writes accepted
    // FREEZE_PEND | freeze requested, writes accepted until next frame start
    // FROZEN      | stored image held, camera writes ignored
    // RESUME_PEND | freeze released, writes resume at next frame start
    typedef enum logic [1:0] {RUN, FREEZE_PEND, FROZEN, RESUME_PEND} state_t;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    state_t state_q, state_d, state_mid;

    logic [18:0]       fifo_addr_q [FIFO_DEPTH];
    logic [35:0]       fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

    logic [18:0] ram_addr_q;
    logic        ram_we_q;
    logic [35:0] ram_wdata_q;
    logic [35:0] disp_data_q;
    logic        disp_valid_q;
    logic        wr_overflow_q;
    logic [15:0] drop_count_q;

    logic empty, full, pop, accept, push_try, push, drop;

    // freeze_req moves the state first; wr_frame then acts on the result
    always_comb begin
        state_mid = state_q;
        case (state_q)
            RUN:         if (freeze_req)  state_mid = FREEZE_PEND;
            FREEZE_PEND: if (!freeze_req) state_mid = RUN;
            FROZEN:      if (!freeze_req) state_mid = RESUME_PEND;
            RESUME_PEND: if (freeze_req)  state_mid = FROZEN;
            default:                      state_mid = RUN;
        endcase
        state_d = state_mid;
        if (wr_frame) begin
            case (state_mid)
                FREEZE_PEND: state_d = FROZEN;
                RESUME_PEND: state_d = RUN;
                default:     state_d = state_mid;
            endcase
        end
        accept = (state_d == RUN) || (state_d == FREEZE_PEND);
    end

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop       = !disp_req && !empty;
        push_try  = wr_req && accept;
        push      = push_try && (!full || pop);
        drop      = push_try && full && !pop;
        rd_pipe_d = RD_LAT'({rd_pipe_q, disp_req});
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q[AW-1:0]] <= wr_addr;
            fifo_data_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RUN;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_pipe_q     <= '0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
            disp_data_q   <= '0;
            disp_valid_q  <= 1'b0;
            wr_overflow_q <= 1'b0;
            drop_count_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_pipe_q <= rd_pipe_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

            if (disp_req) begin
                ram_addr_q <= disp_addr;
                ram_we_q   <= 1'b0;
            end else if (!empty) begin
                ram_addr_q  <= fifo_addr_q[rd_ptr_q[AW-1:0]];
                ram_wdata_q <= fifo_data_q[rd_ptr_q[AW-1:0]];
                ram_we_q    <= 1'b1;
            end else begin
                ram_we_q <= 1'b0;
            end

            // read data is captured on the edge closing the RD_LAT-th cycle after ram_addr
            disp_valid_q <= rd_pipe_q[RD_LAT-1];
            if (rd_pipe_q[RD_LAT-1]) disp_data_q <= ram_rdata;

            if (drop) begin
                wr_overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;
    assign disp_data   = disp_data_q;
    assign disp_valid  = disp_valid_q;
    assign frozen      = (state_q == FROZEN);
    assign wr_overflow = wr_overflow_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// Directed self-checking bench for zbt_port_arbiter: write ordering, read
// priority and latency, overflow, freeze sequencing and mid-run reset.
module tb_zbt_port_arbiter;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [35:0] wr_data;
    logic        wr_frame;
    logic        freeze_req;
    logic        disp_req;
    logic [18:0] disp_addr;
    logic [35:0] disp_data;
    logic        disp_valid;
    logic [18:0] ram_addr;
    logic        ram_we;
    logic [35:0] ram_wdata;
    logic [35:0] ram_rdata = '0;
    logic        frozen;
    logic        wr_overflow;
    logic [15:0] drop_count;

    int n_chk  = 0;
    int n_fail = 0;
    int dv_cnt = 0;
    logic [18:0] wq [$];
    logic [35:0] dq [$];

    zbt_port_arbiter #(.FIFO_DEPTH(4), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_frame(wr_frame), .freeze_req(freeze_req),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_data(disp_data), .disp_valid(disp_valid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .frozen(frozen), .wr_overflow(wr_overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] rd_word(input logic [18:0] a);
        return (a == 19'h00123) ? 36'hABCDE0123 : {17'h0ACE5, a};
    endfunction

    function automatic logic [35:0] wdat(input logic [18:0] a);
        return {17'h1B00D, a};
    endfunction

    // RAM samples the address on the edge after it is presented and drives data for the next cycle
    always @(posedge clk) ram_rdata <= rd_word(ram_addr);

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wq.push_back(ram_addr);
            dq.push_back(ram_wdata);
        end
        if (disp_valid === 1'b1) dv_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [18:0] a);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = wdat(a);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_we"},   64'(ram_we), 64'd0);
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
        chk({tag, "_ram_wdata"}, 64'(ram_wdata), 64'd0);
        chk({tag, "_dvalid"},   64'(disp_valid), 64'd0);
        chk({tag, "_ddata"},    64'(disp_data), 64'd0);
        chk({tag, "_frozen"},   64'(frozen), 64'd0);
        chk({tag, "_ovf"},      64'(wr_overflow), 64'd0);
        chk({tag, "_drops"},    64'(drop_count), 64'd0);
    endtask

    initial begin
        logic any_we;
        reset_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        wr_frame = 1'b0; freeze_req = 1'b0; disp_req = 1'b0; disp_addr = '0;
        tick(); tick();
        chk_all_zero("reset");
        reset_n = 1'b1;

        // 1: three writes commit on consecutive cycles, one cycle after first push
        set_wr(19'h10); tick();
        chk("t1_we_first", 64'(ram_we), 64'd0);
        set_wr(19'h11); tick();
        chk("t1_we0", 64'(ram_we), 64'd1);
        chk("t1_addr0", 64'(ram_addr), 64'h10);
        chk("t1_data0", 64'(ram_wdata), 64'(wdat(19'h10)));
        set_wr(19'h12); tick();
        chk("t1_we1", 64'(ram_we), 64'd1);
        chk("t1_addr1", 64'(ram_addr), 64'h11);
        wr_req = 1'b0; tick();
        chk("t1_we2", 64'(ram_we), 64'd1);
        chk("t1_addr2", 64'(ram_addr), 64'h12);
        tick();
        chk("t1_we_idle", 64'(ram_we), 64'd0);
        chk("t1_addr_hold", 64'(ram_addr), 64'h12);

        // 2: reads hold the port; FIFO fills and two writes drop
        disp_req = 1'b1; disp_addr = 19'h200; any_we = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) set_wr(19'h20 + 19'(i));
            else       wr_req = 1'b0;
            tick();
            any_we |= ram_we;
        end
        chk("t2_no_we", 64'(any_we), 64'd0);
        chk("t2_ovf", 64'(wr_overflow), 64'd1);
        chk("t2_drops", 64'(drop_count), 64'd2);
        disp_req = 1'b0; wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_drain_we", 64'(ram_we), 64'd1);
            chk("t2_drain_addr", 64'(ram_addr), 64'(19'h20 + 19'(i)));
            chk("t2_drain_data", 64'(ram_wdata), 64'(wdat(19'h20 + 19'(i))));
        end
        tick();
        chk("t2_drained", 64'(ram_we), 64'd0);

        // 3: read latency and back-to-back returns
        disp_req = 1'b1; disp_addr = 19'h00123; tick();
        disp_req = 1'b0;
        chk("t3_addr", 64'(ram_addr), 64'h123);
        chk("t3_we", 64'(ram_we), 64'd0);
        chk("t3_dv_c0", 64'(disp_valid), 64'd0);
        tick();
        chk("t3_dv_c1", 64'(disp_valid), 64'd0);
        tick();
        chk("t3_dv_c2", 64'(disp_valid), 64'd1);
        chk("t3_data", 64'(disp_data), 64'h0ABCDE0123);
        tick();
        chk("t3_dv_c3", 64'(disp_valid), 64'd0);
        disp_req = 1'b1; disp_addr = 19'h00123; tick();
        disp_addr = 19'h00124; tick();
        disp_req = 1'b0; tick();
        chk("t3_b2b_dv0", 64'(disp_valid), 64'd1);
        chk("t3_b2b_d0", 64'(disp_data), 64'h0ABCDE0123);
        tick();
        chk("t3_b2b_dv1", 64'(disp_valid), 64'd1);
        chk("t3_b2b_d1", 64'(disp_data), 64'(rd_word(19'h00124)));
        tick();
        chk("t3_b2b_dv2", 64'(disp_valid), 64'd0);

        // 4: freeze at frame start, resume at a later frame start
        wq.delete(); dq.delete();
        freeze_req = 1'b1;
        set_wr(19'h30); tick();
        set_wr(19'h31); tick();
        chk("t4_pend_frozen", 64'(frozen), 64'd0);
        set_wr(19'h32); wr_frame = 1'b1; tick();
        wr_frame = 1'b0;
        chk("t4_frozen", 64'(frozen), 64'd1);
        for (int i = 0; i < 3; i++) begin
            set_wr(19'h33 + 19'(i)); tick();
        end
        chk("t4_still_frozen", 64'(frozen), 64'd1);
        chk("t4_no_drop", 64'(drop_count), 64'd2);
        freeze_req = 1'b0; set_wr(19'h36); tick();
        chk("t4_resume_pend", 64'(frozen), 64'd0);
        set_wr(19'h37); wr_frame = 1'b1; tick();
        wr_frame = 1'b0;
        set_wr(19'h38); tick();
        wr_req = 1'b0;
        repeat (3) tick();
        chk("t4_nwrites", 64'(wq.size()), 64'd4);
        chk("t4_w0", 64'(wq[0]), 64'h30);
        chk("t4_w1", 64'(wq[1]), 64'h31);
        chk("t4_w2", 64'(wq[2]), 64'h37);
        chk("t4_w3", 64'(wq[3]), 64'h38);
        chk("t4_d2", 64'(dq[2]), 64'(wdat(19'h37)));
        chk("t4_drops_end", 64'(drop_count), 64'd2);

        // 5: push into a full FIFO while it pops: no drop, still full afterwards
        wq.delete(); dq.delete();
        disp_req = 1'b1; disp_addr = 19'h300;
        for (int i = 0; i < 4; i++) begin
            set_wr(19'h40 + 19'(i)); tick();
        end
        disp_req = 1'b0; set_wr(19'h44); tick();
        chk("t5_pop_we", 64'(ram_we), 64'd1);
        chk("t5_pop_addr", 64'(ram_addr), 64'h40);
        chk("t5_no_drop", 64'(drop_count), 64'd2);
        disp_req = 1'b1; set_wr(19'h45); tick();
        chk("t5_full_drop", 64'(drop_count), 64'd3);
        disp_req = 1'b0; wr_req = 1'b0;
        repeat (6) tick();
        chk("t5_nwrites", 64'(wq.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            chk("t5_order", 64'(wq[i]), 64'(19'h40 + 19'(i)));

        // 6: reset with queued writes and reads in flight
        disp_req = 1'b1; disp_addr = 19'h400;
        for (int i = 0; i < 3; i++) begin
            set_wr(19'h50 + 19'(i)); tick();
        end
        reset_n = 1'b0; disp_req = 1'b0; wr_req = 1'b0; tick();
        chk_all_zero("t6_reset");
        reset_n = 1'b1;
        wq.delete(); dv_cnt = 0;
        repeat (6) tick();
        chk("t6_no_we", 64'(wq.size()), 64'd0);
        chk("t6_no_dv", 64'(dv_cnt), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
